// File: rtl/io_test_pkg.sv
// -----------------------------------------------------------------------------
// io_test_pkg
// Shared types and constants for the io_test_uart sweep sequencer.
//   state_t    : sequencer FSM states, also exported on the debug state port
//   BAUD_DIV_W : width of one baud divisor table entry / the divisor output
// -----------------------------------------------------------------------------
package io_test_pkg;

    localparam int BAUD_DIV_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        GAP    = 3'd4,
        DONE   = 3'd5
    } state_t;

endpackage

// File: rtl/io_test_cnt.sv
// -----------------------------------------------------------------------------
// io_test_cnt
// Clearable up-counter with a terminal compare. It saturates at all-ones
// instead of wrapping, so an unlimited run never produces a false terminal hit.
// Ports:
//   clk_i, rstn_i : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to 0 (has priority over counting)
//   limit_i       : terminal value; term_o is high while count == limit_i-1
//                   (limit_i == 0 means "no limit", term_o stays low)
//   term_o        : terminal flag, combinational from the counter register
// -----------------------------------------------------------------------------
module io_test_cnt #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         clr_i,
    input  logic [W-1:0] limit_i,
    output logic         term_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (count_q != '1) begin
            count_q <= count_q + W'(1);
        end
    end

    assign term_o = (limit_i != '0) && (count_q == (limit_i - W'(1)));

endmodule

// File: rtl/io_test_sched.sv
// -----------------------------------------------------------------------------
// io_test_sched
// Steps an io_test_uart loopback test through a table of NUM_BAUD baud
// divisors. For each entry: load the divisor, settle, enable the test until
// ut_state_valid or timeout, record the per-IO result, settle again.
//
// Ports:
//   clk, rstn       : clock, asynchronous active-low reset
//   start           : 1-cycle pulse, begins a sweep from IDLE (ignored otherwise)
//   abort           : returns to IDLE from any state, highest priority
//   baud_tbl        : divisor table, entry i = [32*i +: 32], latched on start
//   timeout         : per-entry run limit in cycles (0 = none), latched on start
//   ut_baud_load    : 1-cycle divisor load strobe to io_test_uart
//   ut_baud_div     : divisor to io_test_uart, held between loads
//   ut_en           : test enable to io_test_uart (high only in RUN)
//   ut_state        : per-IO pass bits from io_test_uart
//   ut_state_valid  : ut_state qualifier, only looked at in RUN
//   busy            : high in every state except IDLE
//   done            : 1-cycle pulse when a sweep completes
//   pass            : all result bits set and no timeout; held until next start
//   result          : captured ut_state per entry
//   timeout_flag    : entry i ran into its timeout
//   cur_idx         : table entry currently being processed
//   dbg_state       : current FSM state, for debug/checkers
//
// Handshake: io_test_uart reports completion with a single-cycle
// ut_state_valid while ut_en is high; the sequencer captures ut_state on that
// cycle and drops ut_en on the very next cycle. There is no back-pressure.
// -----------------------------------------------------------------------------
module io_test_sched
    import io_test_pkg::*;
#(
    parameter int OUTPUT_IO_WIDTH = 2,
    parameter int NUM_BAUD        = 4,
    parameter int SETTLE_CYCLES   = 16
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic                                abort,
    input  logic [NUM_BAUD*BAUD_DIV_W-1:0]      baud_tbl,
    input  logic [31:0]                         timeout,
    output logic                                ut_baud_load,
    output logic [BAUD_DIV_W-1:0]               ut_baud_div,
    output logic                                ut_en,
    input  logic [OUTPUT_IO_WIDTH-1:0]          ut_state,
    input  logic                                ut_state_valid,
    output logic                                busy,
    output logic                                done,
    output logic                                pass,
    output logic [NUM_BAUD*OUTPUT_IO_WIDTH-1:0] result,
    output logic [NUM_BAUD-1:0]                 timeout_flag,
    output logic [$clog2(NUM_BAUD):0]           cur_idx,
    output state_t                              dbg_state
);

    localparam int IDX_W = $clog2(NUM_BAUD) + 1;
    localparam int TBL_W = NUM_BAUD * BAUD_DIV_W;
    localparam int RES_W = NUM_BAUD * OUTPUT_IO_WIDTH;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t                  state_q;
    logic [TBL_W-1:0]        tbl_q;
    logic [31:0]             timeout_q;
    logic [IDX_W-1:0]        cur_idx_q;
    logic [BAUD_DIV_W-1:0]   div_q;
    logic                    load_q;
    logic                    en_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    pass_q;
    logic [RES_W-1:0]        result_q;
    logic [NUM_BAUD-1:0]     flag_q;

    // ------------------------------------------------------------------
    // Shared cycle counter
    // SETTLE and GAP count to SETTLE_CYCLES, RUN counts to the latched
    // timeout. The counter is cleared whenever a counting state is left
    // (and in all non-counting states), so every counting state starts
    // from 0 on its first cycle.
    // ------------------------------------------------------------------
    logic        cnt_clr;
    logic [31:0] cnt_limit;
    logic        cnt_term;
    logic        is_last;
    logic        run_valid;
    logic        run_tmo;
    logic        leave_cnt;
    logic [IDX_W-1:0] idx_nxt;

    assign is_last   = (int'(cur_idx_q) == NUM_BAUD - 1);
    assign idx_nxt   = cur_idx_q + IDX_W'(1);
    assign cnt_limit = (state_q == RUN) ? timeout_q : 32'(SETTLE_CYCLES);

    // In RUN a valid report beats a simultaneous timeout.
    assign run_valid = (state_q == RUN) && ut_state_valid;
    assign run_tmo   = (state_q == RUN) && !ut_state_valid && cnt_term;

    always_comb begin
        leave_cnt = 1'b0;
        unique case (state_q)
            SETTLE:  leave_cnt = cnt_term;
            RUN:     leave_cnt = run_valid || run_tmo;
            GAP:     leave_cnt = cnt_term;
            default: leave_cnt = 1'b0;
        endcase
    end

    assign cnt_clr = !((state_q == SETTLE) || (state_q == RUN) || (state_q == GAP))
                     || leave_cnt || abort;

    io_test_cnt #(
        .W (32)
    ) u_cnt (
        .clk_i   (clk),
        .rstn_i  (rstn),
        .clr_i   (cnt_clr),
        .limit_i (cnt_limit),
        .term_o  (cnt_term)
    );

    // ------------------------------------------------------------------
    // Sequencer FSM with registered outputs
    // Output registers are written on the transition into the state they
    // belong to, so ut_baud_load is high exactly during LOAD and ut_en
    // exactly during RUN; the two can never overlap.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            tbl_q     <= '0;
            timeout_q <= '0;
            cur_idx_q <= '0;
            div_q     <= '0;
            load_q    <= 1'b0;
            en_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            result_q  <= '0;
            flag_q    <= '0;
        end else begin
            // Strobes default low every cycle.
            load_q <= 1'b0;
            done_q <= 1'b0;

            if (abort && (state_q != IDLE)) begin
                // Results of completed entries are kept; the sweep as a
                // whole is never reported as passing.
                state_q <= IDLE;
                en_q    <= 1'b0;
                busy_q  <= 1'b0;
                pass_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (start && !abort) begin
                            tbl_q     <= baud_tbl;
                            timeout_q <= timeout;
                            result_q  <= '0;
                            flag_q    <= '0;
                            pass_q    <= 1'b0;
                            cur_idx_q <= '0;
                            // Entry 0 comes straight from the input, the
                            // latched copy is only visible next cycle.
                            div_q     <= baud_tbl[BAUD_DIV_W-1:0];
                            load_q    <= (baud_tbl[BAUD_DIV_W-1:0] != '0);
                            busy_q    <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end

                    LOAD: begin
                        // A zero divisor skips the run entirely; its result
                        // slice and flag stay at their cleared value.
                        state_q <= (div_q != '0) ? SETTLE : GAP;
                    end

                    SETTLE: begin
                        if (cnt_term) begin
                            en_q    <= 1'b1;
                            state_q <= RUN;
                        end
                    end

                    RUN: begin
                        if (run_valid) begin
                            result_q[OUTPUT_IO_WIDTH*int'(cur_idx_q) +: OUTPUT_IO_WIDTH] <= ut_state;
                            en_q    <= 1'b0;
                            state_q <= GAP;
                        end else if (run_tmo) begin
                            result_q[OUTPUT_IO_WIDTH*int'(cur_idx_q) +: OUTPUT_IO_WIDTH] <= '0;
                            flag_q[int'(cur_idx_q) +: 1] <= 1'b1;
                            en_q    <= 1'b0;
                            state_q <= GAP;
                        end
                    end

                    GAP: begin
                        if (cnt_term) begin
                            if (is_last) begin
                                done_q  <= 1'b1;
                                pass_q  <= (&result_q) && !(|flag_q);
                                state_q <= DONE;
                            end else begin
                                cur_idx_q <= idx_nxt;
                                div_q     <= tbl_q[BAUD_DIV_W*int'(idx_nxt) +: BAUD_DIV_W];
                                load_q    <= (tbl_q[BAUD_DIV_W*int'(idx_nxt) +: BAUD_DIV_W] != '0);
                                state_q   <= LOAD;
                            end
                        end
                    end

                    DONE: begin
                        // start seen here is dropped: the sweep has not yet
                        // returned to IDLE.
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end

                    default: begin
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ut_baud_load = load_q;
    assign ut_baud_div  = div_q;
    assign ut_en        = en_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign result       = result_q;
    assign timeout_flag = flag_q;
    assign cur_idx      = cur_idx_q;
    assign dbg_state    = state_q;

endmodule
